// File: rtl/signed_boxcar_avg.sv
// Signed boxcar average over the last 2^P_LOG2_LEN accepted samples; 1-cycle registered latency.
// No backpressure: every valid sample is accepted; empty window slots count as zero.
module signed_boxcar_avg #(
  parameter int P_WIDTH    = 16,
  parameter int P_LOG2_LEN = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [P_WIDTH-1:0] din,
  input  logic               din_valid,
  output logic [P_WIDTH-1:0] dout,
  output logic               dout_valid,
  output logic               primed
);

  localparam int N  = 1 << P_LOG2_LEN;
  localparam int AW = P_WIDTH + P_LOG2_LEN;
  localparam int FW = P_LOG2_LEN + 1;
  localparam logic [FW-1:0] FULL = FW'(N);

  logic [P_WIDTH-1:0]    buf_q [N];
  logic [P_LOG2_LEN-1:0] wp_q;
  logic signed [AW-1:0]  acc_q;
  logic signed [AW-1:0]  acc_d;
  logic [FW-1:0]         fcnt_q;
  logic [FW-1:0]         fcnt_d;
  logic [P_WIDTH-1:0]    dout_q;
  logic [P_WIDTH-1:0]    dout_d;
  logic                  dout_valid_q;
  logic                  primed_q;

  logic signed [AW-1:0]  din_ext;
  logic signed [AW-1:0]  old_ext;
  logic signed [AW-1:0]  avg;

  // acc is always the exact window sum, so the shifted result fits P_WIDTH.
  always_comb begin
    din_ext = {{P_LOG2_LEN{din[P_WIDTH-1]}}, din};
    old_ext = {{P_LOG2_LEN{buf_q[wp_q][P_WIDTH-1]}}, buf_q[wp_q]};
    acc_d   = acc_q + din_ext - old_ext;
    avg     = acc_d >>> P_LOG2_LEN;
    dout_d  = avg[P_WIDTH-1:0];
    fcnt_d  = (fcnt_q == FULL) ? FULL : fcnt_q + FW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= '0;
      end
      wp_q         <= '0;
      acc_q        <= '0;
      fcnt_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      primed_q     <= 1'b0;
    end else if (din_valid) begin
      buf_q[wp_q]  <= din;
      wp_q         <= wp_q + P_LOG2_LEN'(1);
      acc_q        <= acc_d;
      fcnt_q       <= fcnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= 1'b1;
      primed_q     <= (fcnt_d == FULL);
    end else begin
      dout_valid_q <= 1'b0;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign primed     = primed_q;

endmodule

// File: tb/tb_signed_boxcar_avg.sv
// Scoreboard bench for signed_boxcar_avg with P_WIDTH=16, P_LOG2_LEN=3.
module tb_signed_boxcar_avg;

  localparam int W = 16;
  localparam int L = 3;
  localparam int N = 1 << L;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         primed;

  signed_boxcar_avg #(.P_WIDTH(W), .P_LOG2_LEN(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int p;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   win[N];
  int   wpm;
  int   fill;
  int   last_d;
  int   last_p;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) win[i] = 0;
    wpm    = 0;
    fill   = 0;
    last_d = 0;
    last_p = 0;
  endtask

  function automatic int dout_s();
    return int'($signed(dout));
  endfunction

  // One clock: drive at negedge, model the cycle, check just after the posedge.
  task automatic step(input bit v, input int d, input bit c = 1'b0, input bit r = 1'b0);
    exp_t e;
    int   sum;
    bit   exp_vld;
    @(negedge clk);
    din       = W'(d);
    din_valid = v;
    clr       = c;
    rst       = r;
    exp_vld   = 1'b0;
    if (r || c) begin
      model_reset();
    end else if (v) begin
      win[wpm] = d;
      wpm      = (wpm + 1) % N;
      if (fill < N) fill++;
      sum = 0;
      for (int i = 0; i < N; i++) sum += win[i];
      e.d = floor_div(sum, N);
      e.p = (fill == N) ? 1 : 0;
      exp_q.push_back(e);
      exp_vld = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("dout_valid", int'(dout_valid), int'(exp_vld));
    if (dout_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("dout", dout_s(), e.d);
        chk("primed", int'(primed), e.p);
        last_d = e.d;
        last_p = e.p;
      end
    end else begin
      chk("dout_hold", dout_s(), last_d);
      chk("primed_hold", int'(primed), last_p);
    end
  endtask

  initial begin
    model_reset();
    din_valid = 1'b0;

    // reset state
    step(0, 0, 0, 1);
    step(0, 0);

    // ramp up with 800s, then down with -800s
    for (int i = 0; i < N; i++) step(1, 800);
    chk("ramp_end", dout_s(), 800);
    chk("ramp_primed", int'(primed), 1);
    for (int i = 0; i < N; i++) step(1, -800);
    chk("ramp_down_end", dout_s(), -800);

    // floor rounding
    step(0, 0, 0, 1);
    step(1, -1);
    chk("floor_m1", dout_s(), -1);
    step(1, 7);
    chk("floor_6", dout_s(), 0);
    step(1, 2);
    chk("floor_8", dout_s(), 1);

    // extremes
    for (int i = 0; i < N; i++) step(1, -32768);
    chk("all_min", dout_s(), -32768);
    for (int i = 0; i < N; i++) step(1, 32767);
    chk("all_max", dout_s(), 32767);

    // gapped valid
    step(0, 0, 0, 1);
    step(1, 80); step(0, 80); step(0, 80);
    step(1, 80); step(0, 80); step(1, 80);
    chk("gap_end", dout_s(), 30);

    // clr with valid drops the sample, then rst does the same
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 1);
      for (int i = 0; i < N; i++) step(1, 800);
      step(1, 5000, (k == 0), (k == 1));
      chk("flush_dout", dout_s(), 0);
      chk("flush_primed", int'(primed), 0);
      step(1, 80);
      chk("after_flush", dout_s(), 10);
    end

    // random stream with occasional clr for wrap coverage
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 65535)) - 32768,
           ($urandom_range(0, 60) == 0));
    end

    step(0, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/signed_boxcar_avg.md
Name: signed_boxcar_avg

Overview:
- Signed moving-average (boxcar) filter over the last 2^P_LOG2_LEN accepted samples.
- Sits directly upstream of the signed clip stage. Its dout drives the clip stage's data input.
- Valid-qualified streaming input. Registered output with a fixed 1-cycle latency.
- No backpressure: the downstream clip stage is combinational and always ready.

Parameters:
- P_WIDTH, 16, sample width in bits (two's complement) for din and dout.
- P_LOG2_LEN, 3, log2 of window length. Window N = 2^P_LOG2_LEN. Legal range 1..6.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- clr  input  1  synchronous flush of window state; same effect as rst, outputs included.
- din  input  P_WIDTH  signed input sample.
- din_valid  input  1  din is accepted on this cycle.
- dout  output  P_WIDTH  signed window average (registered).
- dout_valid  output  1  1-cycle strobe; dout updated this cycle.
- primed  output  1  high once N samples have been accepted since the last rst/clr.

Behaviour:
- Storage:
  - N-entry register array buf[0..N-1], each P_WIDTH signed.
  - Write pointer wp, P_LOG2_LEN bits, wraps N-1 -> 0.
  - Running sum acc, signed, P_WIDTH+P_LOG2_LEN bits; cannot overflow.
  - Fill counter fcnt, P_LOG2_LEN+1 bits; saturates at N.
- Reset (rst=1), and clr=1:
  - All buf entries cleared to 0; acc, wp, fcnt cleared to 0.
  - dout=0, dout_valid=0, primed=0.
  - rst has priority over everything. clr has priority over din_valid: a sample presented with clr is dropped.
- Accept cycle (din_valid=1, no rst/clr):
  - acc_next = acc + sext(din) - sext(buf[wp]).
  - buf[wp] <= din; wp <= wp+1 (mod N); acc <= acc_next.
  - dout <= acc_next >>> P_LOG2_LEN, i.e. arithmetic shift, floor toward -inf, then truncated to P_WIDTH. The result always fits.
  - dout_valid <= 1.
  - fcnt <= min(fcnt+1, N).
- Idle cycle (din_valid=0):
  - All state held; dout holds its last value; dout_valid <= 0.
- Latency: dout/dout_valid are asserted on the cycle after din_valid is sampled high.
  - Back-to-back din_valid gives back-to-back dout_valid; throughput is 1 sample/clk.
- Priming:
  - Before N samples have been accepted, empty slots count as 0 and the output ramps (a true sum/N with zeros).
  - primed = (fcnt == N), registered. It rises together with the dout_valid of the Nth sample.
  - primed stays high until rst/clr.
- Wrap-around: after wp wraps, the oldest sample is subtracted; acc always equals the sum of buf.
- Extremes: all-max gives 2^(P_WIDTH-1)-1; all-min gives -2^(P_WIDTH-1). No saturation logic is needed or allowed.
- rst/clr mid-stream: the next accepted sample behaves as the first after reset.

Test Plan (P_WIDTH=16, P_LOG2_LEN=3):
- rst, then 8 consecutive din=800 with valid:
  - dout = 100,200,...,800 on successive cycles, each 1 cycle after its input.
  - primed rises with the dout=800 strobe.
- Continue with 8 consecutive din=-800:
  - dout = 600,400,200,0,-200,-400,-600,-800. primed stays 1.
- rst, then din=-1 -> dout=-1 (floor); next din=7 -> dout=0; next din=2 -> dout=1.
- 8 × din=-32768 -> final dout=-32768. Then 8 × din=32767 -> final dout=32767. No wrap or overflow at any step.
- Gapped valid (pattern 1,0,0,1,0,1 with din=80 each):
  - dout = 10,20,30, each 1 cycle after its valid.
  - dout_valid low on gap cycles; dout held during gaps.
- After priming with 800s, assert clr together with din_valid, din=5000:
  - Sample dropped; dout=0, primed=0.
  - Next din=80 -> dout=10.
  - Repeat the sequence using rst instead of clr: identical result.
